asym_flush_fifo: RTL

Parametrised asymmetric-width FIFO with flush: narrow write units packed into wide read words, with a flush mechanism that emits zero-padded partial words. Successor to the fixed 4-bit/32-bit, 128-bit flush FIFO. Adds configurable widths, depth and packing order, write backpressure, a fill-level output and a padded-word indicator. Sits between a narrow producer (e.g. nibble serializer) and a wide consumer that may need to drain short bursts on demand.

---
 rtl/asym_fifo_pkg.sv | 31 +++
 rtl/asym_fifo_mem.sv | 32 +++
 rtl/asym_flush_fifo.sv | 102 ++++++++++
 3 files changed

// File: rtl/asym_fifo_pkg.sv
// rtl/asym_fifo_pkg.sv - shared flush state type and read-word packing for asym_flush_fifo
package asym_fifo_pkg;

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} flush_state_e;

  localparam int unsigned PACK_MAX = 256;
  localparam int unsigned PACK_IW  = 8;

  // units carries the read window oldest-first from bit 0; slots at or beyond take read as zero
  function automatic logic [PACK_MAX-1:0] pack_units(
    input logic [PACK_MAX-1:0] units,
    input int unsigned         take,
    input bit                  lsb_first,
    input int unsigned         wr_w,
    input int unsigned         ratio
  );
    logic [PACK_MAX-1:0] word;
    int unsigned u;
    int unsigned pos;
    word = '0;
    for (int unsigned b = 0; b < PACK_MAX; b++) begin
      u = b / wr_w;
      if (u < take && u < ratio) begin
        pos = lsb_first ? b : (ratio - 1 - u) * wr_w + (b % wr_w);
        word[pos[PACK_IW-1:0]] = units[b];
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/asym_fifo_mem.sv
// rtl/asym_fifo_mem.sv - unit storage with one write port and a wrapping RATIO-unit read window
module asym_fifo_mem #(
  parameter int WR_W  = 4,
  parameter int RATIO = 8,
  parameter int CAP   = 32,
  parameter int AW    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WR_W-1:0]       wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [RATIO*WR_W-1:0] window
);

  logic [WR_W-1:0] mem [CAP];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CAP; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // CAP is a power of two, so the address sum wraps naturally
  for (genvar i = 0; i < RATIO; i++) begin : g_win
    assign window[i*WR_W +: WR_W] = mem[rd_addr + AW'(i)];
  end

endmodule

// File: rtl/asym_flush_fifo.sv
// rtl/asym_flush_fifo.sv - narrow-write / wide-read FIFO with flush that emits zero-padded partial words
module asym_flush_fifo
  import asym_fifo_pkg::*;
#(
  parameter int WR_W      = 4,
  parameter int RD_W      = 32,
  parameter int RD_DEPTH  = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr_valid,
  input  logic [WR_W-1:0]                         wr_data,
  output logic                                    wr_ready,
  output logic                                    rd_valid,
  input  logic                                    rd_ready,
  output logic [RD_W-1:0]                         rd_data,
  output logic                                    rd_partial,
  input  logic                                    flush_req,
  output logic                                    flush_done,
  output logic                                    full,
  output logic                                    empty,
  output logic [$clog2(RD_W/WR_W*RD_DEPTH):0]     level
);

  localparam int RATIO = RD_W / WR_W;
  localparam int CAP   = RATIO * RD_DEPTH;
  localparam int PW    = $clog2(CAP) + 1;
  localparam int AW    = PW - 1;
  localparam logic [PW-1:0] RATIO_P = PW'(RATIO);
  localparam logic [PW-1:0] CAP_P   = PW'(CAP);

  flush_state_e state, state_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr, mark, avail, take, rd_ptr_nxt;
  logic wr_fire, rd_fire, in_flush;
  logic [RD_W-1:0] window, packed_word;
  logic [PACK_MAX-1:0] window_ext;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == CAP_P);
  assign empty    = (level == '0);
  assign wr_ready = !full;
  assign wr_fire  = wr_valid && wr_ready;

  // During a flush only units older than mark may leave, so the pop may shrink
  assign in_flush   = (state == FLUSH);
  assign avail      = mark - rd_ptr;
  assign take       = (in_flush && avail < RATIO_P) ? avail : RATIO_P;
  assign rd_valid   = (level >= RATIO_P) || (in_flush && rd_ptr != mark);
  assign rd_fire    = rd_valid && rd_ready;
  assign rd_ptr_nxt = rd_fire ? rd_ptr + take : rd_ptr;

  assign window_ext  = PACK_MAX'(window);
  assign packed_word = RD_W'(pack_units(window_ext, 32'(take), LSB_FIRST, WR_W, RATIO));
  assign rd_data     = rd_valid ? packed_word : '0;
  assign rd_partial  = rd_valid && (take < RATIO_P);

  asym_fifo_mem #(
    .WR_W  (WR_W),
    .RATIO (RATIO),
    .CAP   (CAP),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[AW-1:0]),
    .window  (window)
  );

  always_comb begin
    state_nxt  = state;
    flush_done = 1'b0;
    case (state)
      IDLE:    if (flush_req) state_nxt = FLUSH;
      FLUSH:   if (rd_ptr_nxt == mark) state_nxt = DONE;
      DONE: begin
        flush_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      mark   <= '0;
    end else begin
      state  <= state_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (wr_fire) wr_ptr <= wr_ptr + PW'(1);
      // a write in the capture cycle belongs to the flush
      if (state == IDLE && flush_req) mark <= wr_ptr + PW'(wr_fire);
    end
  end

endmodule
